cla_serial_word_adder: RTL

//  Multi-cycle wide-word adder that feeds the team's 4-bit carry-lookahead adder slice.

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla4_slice.sv | 32 +++
 rtl/cla_serial_word_adder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead word adder.
package cla_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when a word width can be split into whole nibbles.
  function automatic bit width_ok(input int unsigned w);
    return (w >= NIBBLE_W) && ((w % NIBBLE_W) == 0);
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] c;

  // Bitwise generate/propagate terms.
  assign g = a & b;
  assign p = a ^ b;

  // Every carry expanded directly from g/p/cin so no carry waits on another.
  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
  end

  assign sum = p ^ c;

endmodule

// File: rtl/cla_serial_word_adder.sv
// Wide-word adder that walks the operands one nibble per cycle through a
// single CLA slice, with valid/ready handshakes on both sides.
module cla_serial_word_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  // Reject widths that do not split into whole nibbles.
  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("cla_serial_word_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t              state;
  state_t              state_next;
  logic [WIDTH-1:0]    a_sh;
  logic [WIDTH-1:0]    b_sh;
  logic [WIDTH-1:0]    sum_sh;
  logic [WIDTH-1:0]    sum_next;
  logic                carry_reg;
  logic [IDX_W-1:0]    idx;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                load;
  logic                step;
  logic                last;
  logic                deliver;

  // The only arithmetic: current low nibbles plus the registered carry.
  cla4_slice u_slice (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New sum nibble enters at the MSB end so the word is aligned after the last step.
  assign sum_next = (sum_sh >> NIBBLE_W) | (WIDTH'(slice_sum) << (WIDTH - NIBBLE_W));

  // Handshake-facing flags decode from state alone.
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    deliver    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (idx == LAST_IDX) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          deliver    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand/sum shift registers, carry chain register and nibble index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
    end else if (load) begin
      a_sh      <= in_a;
      b_sh      <= in_b;
      sum_sh    <= '0;
      carry_reg <= in_cin;
      idx       <= '0;
    end else if (step) begin
      a_sh      <= a_sh >> NIBBLE_W;
      b_sh      <= b_sh >> NIBBLE_W;
      sum_sh    <= sum_next;
      carry_reg <= slice_cout;
      idx       <= idx + IDX_W'(1);
    end
  end

  // Result registers: captured on the final nibble, held until the consumer takes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_valid <= 1'b0;
    end else if (last) begin
      out_sum   <= sum_next;
      out_carry <= slice_cout;
      out_valid <= 1'b1;
    end else if (deliver) begin
      out_valid <= 1'b0;
    end
  end

endmodule
